// File: rtl/nbit_piso_tx.sv
// ============================================================================
// nbit_piso_tx : N-bit parallel-in/serial-out transmitter, MSB first.
// Optional even-parity bit after the data bits (macro NBIT_PISO_TX_PARITY_EN).
// Revision 1.0
// ============================================================================
`default_nettype none

module nbit_piso_tx #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] data_in,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_data,
  output logic         ser_last,
  output logic         busy,
  output logic         done
);

  localparam int             CW       = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(N - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef NBIT_PISO_TX_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [N-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic          last_bit;
`ifdef NBIT_PISO_TX_PARITY_EN
  logic          par;
`endif

  assign last_bit = (cnt == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (load_valid) begin
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (ser_ready && last_bit) begin
`ifdef NBIT_PISO_TX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef NBIT_PISO_TX_PARITY_EN
      S_PARITY: begin
        if (ser_ready) begin
          state_nxt = S_IDLE;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    ser_last   = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        load_ready = 1'b1;
        busy       = 1'b0;
      end
      S_SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = shreg[N-1];
`ifndef NBIT_PISO_TX_PARITY_EN
        ser_last  = last_bit;
`endif
      end
`ifdef NBIT_PISO_TX_PARITY_EN
      S_PARITY: begin
        ser_valid = 1'b1;
        ser_data  = par;
        ser_last  = 1'b1;
      end
`endif
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Datapath and the registered done pulse: done marks the first IDLE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
`ifdef NBIT_PISO_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done <= (state != S_IDLE) && (state_nxt == S_IDLE);
      case (state)
        S_IDLE: begin
          if (load_valid) begin
            shreg <= data_in;
            cnt   <= '0;
`ifdef NBIT_PISO_TX_PARITY_EN
            par   <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          if (ser_ready) begin
            shreg <= {shreg[N-2:0], 1'b0};
            cnt   <= cnt + CW'(1);
`ifdef NBIT_PISO_TX_PARITY_EN
            par   <= par ^ shreg[N-1];
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nbit_piso_tx.sv
// ============================================================================
// tb_nbit_piso_tx : directed self-checking bench for nbit_piso_tx (N=8 and N=2).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_nbit_piso_tx;

`ifdef NBIT_PISO_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] data_in = '0;
  logic       ser_valid;
  logic       ser_ready = 1'b0;
  logic       ser_data;
  logic       ser_last;
  logic       busy;
  logic       done;

  logic       n2_load_valid = 1'b0;
  logic       n2_load_ready;
  logic [1:0] n2_data_in = '0;
  logic       n2_ser_valid;
  logic       n2_ser_ready = 1'b0;
  logic       n2_ser_data;
  logic       n2_ser_last;
  logic       n2_busy;
  logic       n2_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nbit_piso_tx #(.N(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_data   (ser_data),
    .ser_last   (ser_last),
    .busy       (busy),
    .done       (done)
  );

  nbit_piso_tx #(.N(2)) dut_n2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (n2_load_valid),
    .load_ready (n2_load_ready),
    .data_in    (n2_data_in),
    .ser_valid  (n2_ser_valid),
    .ser_ready  (n2_ser_ready),
    .ser_data   (n2_ser_data),
    .ser_last   (n2_ser_last),
    .busy       (n2_busy),
    .done       (n2_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w);
    load_valid = 1'b1;
    data_in    = w;
    tick();
    load_valid = 1'b0;
  endtask

  // Expects the frame already loaded and ser_ready=1; ends in the done cycle.
  task automatic run_frame(input string tag, input logic [7:0] bits, input logic p);
    for (int i = 0; i < 8; i++) begin
      chk({tag, ".valid"}, ser_valid, 1'b1);
      chk({tag, ".data"},  ser_data,  bits[7-i]);
      chk({tag, ".last"},  ser_last,  (i == 7) && !PAR_EN);
      chk({tag, ".busy"},  busy,      1'b1);
      chk({tag, ".lrdy"},  load_ready, 1'b0);
      chk({tag, ".done0"}, done,      1'b0);
      tick();
    end
    if (PAR_EN) begin
      chk({tag, ".pvalid"}, ser_valid, 1'b1);
      chk({tag, ".pdata"},  ser_data,  p);
      chk({tag, ".plast"},  ser_last,  1'b1);
      tick();
    end
    chk({tag, ".done"},     done,       1'b1);
    chk({tag, ".idle_rdy"}, load_ready, 1'b1);
    chk({tag, ".idle_vld"}, ser_valid,  1'b0);
    chk({tag, ".idle_bsy"}, busy,       1'b0);
    chk({tag, ".idle_dat"}, ser_data,   1'b0);
  endtask

  initial begin
    // Reset values while reset_n is held low
    #12;
    chk("rst.load_ready", load_ready, 1'b1);
    chk("rst.ser_valid",  ser_valid,  1'b0);
    chk("rst.ser_data",   ser_data,   1'b0);
    chk("rst.ser_last",   ser_last,   1'b0);
    chk("rst.busy",       busy,       1'b0);
    chk("rst.done",       done,       1'b0);
    chk("rst.n2_ready",   n2_load_ready, 1'b1);
    reset_n = 1'b1;
    tick();

    // A5 with ser_ready held high
    ser_ready = 1'b1;
    load_word(8'hA5);
    run_frame("a5", 8'b1010_0101, 1'b0);
    tick();
    chk("a5.done_pulse", done, 1'b0);

    // 80 with ser_ready stalled for 5 cycles; a load pulse must be ignored
    ser_ready = 1'b0;
    load_word(8'h80);
    for (int i = 0; i < 5; i++) begin
      load_valid = (i == 2);
      data_in    = 8'h55;
      chk("stall.valid", ser_valid, 1'b1);
      chk("stall.data",  ser_data,  1'b1);
      chk("stall.last",  ser_last,  1'b0);
      chk("stall.lrdy",  load_ready, 1'b0);
      tick();
    end
    load_valid = 1'b0;
    ser_ready  = 1'b1;
    run_frame("s80", 8'b1000_0000, 1'b1);
    tick();

    // Back-to-back: FF then 01 with load_valid held high
    load_valid = 1'b1;
    data_in    = 8'hFF;
    tick();
    data_in    = 8'h01;
    run_frame("ff", 8'b1111_1111, 1'b0);
    tick();
    load_valid = 1'b0;
    run_frame("b01", 8'b0000_0001, 1'b1);
    tick();

    // Reset mid-frame after the third bit of C3
    load_word(8'hC3);
    tick();
    tick();
    tick();
    chk("abort.pre_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort.valid", ser_valid,  1'b0);
    chk("abort.data",  ser_data,   1'b0);
    chk("abort.last",  ser_last,   1'b0);
    chk("abort.busy",  busy,       1'b0);
    chk("abort.lrdy",  load_ready, 1'b1);
    chk("abort.done",  done,       1'b0);
    #4;
    reset_n = 1'b1;
    tick();
    chk("abort.no_done", done, 1'b0);
    chk("abort.idle",    busy, 1'b0);
    load_word(8'h3C);
    run_frame("3c", 8'b0011_1100, 1'b0);
    tick();

    // Parity vectors (data-only frames in the default build)
    load_word(8'h07);
    run_frame("p07", 8'b0000_0111, 1'b1);
    tick();
    load_word(8'h03);
    run_frame("p03", 8'b0000_0011, 1'b0);
    tick();

    // N=2 instance: 2'b10
    n2_ser_ready  = 1'b1;
    n2_load_valid = 1'b1;
    n2_data_in    = 2'b10;
    tick();
    n2_load_valid = 1'b0;
    chk("n2.b0.valid", n2_ser_valid, 1'b1);
    chk("n2.b0.data",  n2_ser_data,  1'b1);
    chk("n2.b0.last",  n2_ser_last,  1'b0);
    tick();
    chk("n2.b1.data",  n2_ser_data,  1'b0);
    chk("n2.b1.last",  n2_ser_last,  !PAR_EN);
    tick();
    if (PAR_EN) begin
      chk("n2.par.data", n2_ser_data, 1'b1);
      chk("n2.par.last", n2_ser_last, 1'b1);
      tick();
    end
    chk("n2.done",  n2_done,       1'b1);
    chk("n2.ready", n2_load_ready, 1'b1);
    tick();
    chk("n2.done_pulse", n2_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nbit_piso_tx.md
# nbit_piso_tx

Parallel-in/serial-out transmitter for the register path. It accepts one N-bit word through a valid/ready load handshake and shifts it out MSB-first, one bit per accepted serial handshake. It sits downstream of the N-bit holding registers and reads a word into a serial link. An optional even-parity bit is appended after the data bits.

## Interface
- N, 8, data word width; legal range N >= 2.
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  data_in is valid for capture.
- load_ready  output  1  block can accept a word; high only in IDLE.
- data_in  input  N  parallel word to transmit.
- ser_valid  output  1  ser_data holds a valid bit.
- ser_ready  input  1  sink accepts the current bit.
- ser_data  output  1  current serial bit; forced to 0 when ser_valid=0.
- ser_last  output  1  current bit is the final bit of the frame.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse after the final bit is accepted.

## Operation
- Reset (reset_n=0, asynchronous): state=IDLE; shift register and bit counter cleared; ser_valid=0, ser_data=0, ser_last=0, busy=0, done=0; load_ready=1 (reflects IDLE, including while reset_n is low).
- Reset mid-frame aborts the frame immediately. No done pulse. Partial bits are not replayed.
- Bit counter width is $clog2(N+1). It counts accepted data bits 0..N-1.
- States: IDLE, SHIFT, PARITY (PARITY only present with the macro defined).
- IDLE:
  - load_ready=1, ser_valid=0.
  - On load_valid && load_ready: capture data_in into the shift register, clear the counter, clear the parity accumulator, go to SHIFT.
- SHIFT:
  - ser_valid=1, ser_data=shreg[N-1], load_ready=0. load_valid is ignored.
  - On ser_valid && ser_ready: shift left by one (zero fill), increment the counter, XOR the sent bit into the parity accumulator.
  - When the accepted bit has counter==N-1: go to PARITY if enabled, else go to IDLE and assert done on the next cycle.
  - If ser_ready=0: hold ser_data, state and counter unchanged. No timeout.
- PARITY:
  - ser_valid=1, ser_data=XOR of all N data bits (even parity), ser_last=1.
  - On ser_ready: go to IDLE; done asserts the next cycle.
- ser_last=1 only while the last bit of the frame is presented: data bit N-1 without parity, the parity bit with parity.
- done is registered. It is high exactly one cycle, coincident with the first IDLE cycle after the frame.

## Timing
- Load accepted at rising edge k: ser_valid=1 and ser_data=data_in[N-1] from cycle k+1.
- Continuous ser_ready=1: one bit per cycle. A frame occupies N cycles (N+1 with parity) after the load edge.
- Back-to-back frames: load_ready returns to 1 in the same cycle done pulses. The next load can be accepted at that edge, giving one idle serial cycle between frames.
- The ser_* outputs and load_ready are decoded from registered state only. There are no combinational paths from ser_ready or load_valid to any output.

## Configuration
- Macro: NBIT_PISO_TX_PARITY_EN.
- Defined: the PARITY state and accumulator are compiled in. The frame is N data bits followed by one even-parity bit, and ser_last marks the parity bit.
- Undefined: no PARITY state or accumulator logic. The frame is N bits and ser_last marks data bit N-1.

## Test plan
- Reset then load 8'hA5 with ser_ready held 1 -> ser_data sequence 1,0,1,0,0,1,0,1 on consecutive cycles. ser_last only on the 8th bit. done pulses one cycle later. busy=1 for 8 cycles.
- Load 8'h80, hold ser_ready=0 for 5 cycles after ser_valid rises -> ser_data=1 held stable, counter frozen, load_ready=0. A load_valid pulse in this window is ignored.
- Back-to-back loads of 8'hFF then 8'h01 with load_valid held 1 -> the second word is captured in the done cycle. Output is 1×8, one gap cycle, then 0,0,0,0,0,0,0,1.
- Assert reset_n=0 after the 3rd bit of 8'hC3 -> outputs go to reset values asynchronously, no done pulse. A following load of 8'h3C transmits cleanly.
- With NBIT_PISO_TX_PARITY_EN defined, load 8'h07 -> 8 data bits, then parity bit 1 with ser_last=1. Load 8'h03 -> parity bit 0.
- N=2 build: load 2'b10 -> bits 1,0. ser_last on the second bit. done one cycle later.
